pwm_multi_dt: RTL and testbench

// Multi-channel, width-parametrised PWM generator with complementary outputs and

---
 rtl/pwm_multi_dt_if.sv | 24 ++
 rtl/pwm_multi_dt.sv | 116 +++++++++++
 tb/tb_pwm_multi_dt.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_dt_if.sv
// rtl/pwm_multi_dt_if.sv - control and gate-drive signal bundle for pwm_multi_dt
interface pwm_multi_dt_if #(
    parameter int WIDTH = 11,
    parameter int NCH   = 2,
    parameter int DT_W  = 5
);
    logic                 en;
    logic [NCH*WIDTH-1:0] duty_in;
    logic                 duty_wr;
    logic [DT_W-1:0]      deadtime;
    logic [NCH-1:0]       PWM_sig;
    logic [NCH-1:0]       PWM_sig_n;
    logic                 period_st;

    modport master (
        output en, duty_in, duty_wr, deadtime,
        input  PWM_sig, PWM_sig_n, period_st
    );

    modport slave (
        input  en, duty_in, duty_wr, deadtime,
        output PWM_sig, PWM_sig_n, period_st
    );
endinterface

// File: rtl/pwm_multi_dt.sv
// rtl/pwm_multi_dt.sv - multi-channel PWM with shared counter, shadowed duty and dead-time gate pairs
module pwm_multi_dt #(
    parameter int WIDTH = 11,
    parameter int NCH   = 2,
    parameter int DT_W  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_multi_dt_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_LO, ST_DHI, ST_HI, ST_DLO} st_e;

    logic [WIDTH-1:0]            cnt_q, cnt_d;
    logic [NCH-1:0][WIDTH-1:0]   pending_q, pending_d;
    logic [NCH-1:0][WIDTH-1:0]   active_q, active_d;
    logic [NCH-1:0]              raw_q, raw_d;
    logic                        period_st_q, period_st_d;
    logic [NCH-1:0][DT_W-1:0]    dcnt_q, dcnt_d;
    st_e                         state_q [NCH];
    st_e                         state_d [NCH];
    logic [NCH-1:0]              sig, sig_n;
    logic                        load;

    // Active duty only moves at a period boundary, or continuously while stopped.
    assign load = ~bus.en | (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d       = bus.en ? cnt_q + WIDTH'(1) : '0;
        period_st_d = bus.en & (cnt_q == CNT_MAX);
        pending_d   = pending_q;
        active_d    = active_q;
        raw_d       = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.duty_wr) pending_d[i] = bus.duty_in[i*WIDTH +: WIDTH];
            if (load)        active_d[i]  = pending_q[i];
            raw_d[i] = bus.en & (cnt_q < active_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pending_q   <= '0;
            active_q    <= '0;
            raw_q       <= '0;
            period_st_q <= 1'b0;
            dcnt_q      <= '0;
            for (int i = 0; i < NCH; i++) state_q[i] <= ST_LO;
        end else begin
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            raw_q       <= raw_d;
            period_st_q <= period_st_d;
            dcnt_q      <= dcnt_d;
            for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
        end
    end

    // A reversal of raw_q inside a dead band returns straight to the previous
    // driven state, so pulses shorter than the dead time never reach the gates.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            case (state_q[i])
                ST_LO: begin
                    if (raw_q[i]) begin
                        if (bus.deadtime == '0) begin
                            state_d[i] = ST_HI;
                        end else begin
                            state_d[i] = ST_DHI;
                            dcnt_d[i]  = bus.deadtime - DT_W'(1);
                        end
                    end
                end
                ST_DHI: begin
                    if (!raw_q[i])             state_d[i] = ST_LO;
                    else if (dcnt_q[i] == '0)  state_d[i] = ST_HI;
                    else                       dcnt_d[i]  = dcnt_q[i] - DT_W'(1);
                end
                ST_HI: begin
                    if (!raw_q[i]) begin
                        if (bus.deadtime == '0) begin
                            state_d[i] = ST_LO;
                        end else begin
                            state_d[i] = ST_DLO;
                            dcnt_d[i]  = bus.deadtime - DT_W'(1);
                        end
                    end
                end
                ST_DLO: begin
                    if (raw_q[i])              state_d[i] = ST_HI;
                    else if (dcnt_q[i] == '0)  state_d[i] = ST_LO;
                    else                       dcnt_d[i]  = dcnt_q[i] - DT_W'(1);
                end
                default: state_d[i] = ST_LO;
            endcase
        end
    end

    always_comb begin
        sig   = '0;
        sig_n = '0;
        for (int i = 0; i < NCH; i++) begin
            sig[i]   = (state_q[i] == ST_HI);
            sig_n[i] = (state_q[i] == ST_LO);
        end
    end

    assign bus.PWM_sig   = sig;
    assign bus.PWM_sig_n = sig_n;
    assign bus.period_st = period_st_q;
endmodule

// File: tb/tb_pwm_multi_dt.sv
// tb/tb_pwm_multi_dt.sv - self-checking bench for pwm_multi_dt (WIDTH=4, NCH=2, DT_W=3)
module tb_pwm_multi_dt;
    localparam int W  = 4;
    localparam int N  = 2;
    localparam int DW = 3;

    typedef struct {
        int s0;
        int n0;
        int s1;
        int n1;
    } exp_t;

    typedef struct {
        logic [W-1:0]  d0;
        logic [W-1:0]  d1;
        logic [DW-1:0] dt;
        exp_t          e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    pwm_multi_dt_if #(.WIDTH(W), .NCH(N), .DT_W(DW)) bus ();

    pwm_multi_dt #(.WIDTH(W), .NCH(N), .DT_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d0, input int d1, input int dt,
                                input int s0, input int n0, input int s1, input int n1);
        vec_t v;
        v.d0 = W'(d0);
        v.d1 = W'(d1);
        v.dt = DW'(dt);
        v.e.s0 = s0;
        v.e.n0 = n0;
        v.e.s1 = s1;
        v.e.n1 = n1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) chk("overlap", 32'(bus.PWM_sig & bus.PWM_sig_n), 32'd0);
    end

    task automatic wait_pst();
        int  cyc;
        bit  ok;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40 && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.period_st) ok = 1'b1;
        end
        chk("period_st_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_pst_gap(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.period_st) break;
        end
    endtask

    task automatic apply_duty(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [DW-1:0] dt);
        bus.duty_in  = {d1, d0};
        bus.deadtime = dt;
        bus.duty_wr  = 1'b1;
        @(negedge clk);
        bus.duty_wr  = 1'b0;
    endtask

    // One period window starting at the cnt==0 cycle; optionally writes ch0 duty at cnt==wr_at.
    task automatic run_window(input int wr_at, input logic [W-1:0] wr_val, output int hi);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            bus.duty_wr = 1'b0;
            hi += int'(bus.PWM_sig[0]);
            if (i == wr_at) begin
                bus.duty_in = {W'(0), wr_val};
                bus.duty_wr = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int   gap;
        int   hi;
        int   cs0, cn0, cs1, cn1, cp;
        bit   found;
        logic prev_n;
        exp_t e;
        logic [1:0] drop_exp [4];

        vecs[0] = mk(4,  12, 0,  4, 12, 12,  4);
        vecs[1] = mk(8,  0,  3,  5,  5,  0, 16);
        vecs[2] = mk(3,  15, 5,  0, 13, 15,  0);
        vecs[3] = mk(0,  15, 0,  0, 16, 15,  1);
        vecs[4] = mk(15, 1,  1, 15,  0,  0, 15);
        vecs[5] = mk(10, 6,  7, 10,  0,  0, 10);
        vecs[6] = mk(12, 5,  2, 10,  2,  3,  9);
        drop_exp[0] = 2'b10;
        drop_exp[1] = 2'b00;
        drop_exp[2] = 2'b00;
        drop_exp[3] = 2'b01;

        bus.en       = 1'b1;
        bus.duty_in  = '0;
        bus.duty_wr  = 1'b0;
        bus.deadtime = '0;

        // Reset held with en=1, then free-running period check.
        repeat (3) @(negedge clk);
        chk("rst_sig",   32'(bus.PWM_sig),   32'd0);
        chk("rst_sig_n", 32'(bus.PWM_sig_n), 32'd3);
        chk("rst_pst",   32'(bus.period_st), 32'd0);
        rst_n = 1'b1;
        wait_pst_gap(gap);
        chk("first_period", 32'(gap), 32'd16);
        wait_pst_gap(gap);
        chk("second_period", 32'(gap), 32'd16);

        // Steady-state high counts per period for each table row.
        for (int v = 0; v < 7; v++) begin
            apply_duty(vecs[v].d0, vecs[v].d1, vecs[v].dt);
            sb_q.push_back(vecs[v].e);
            repeat (3) wait_pst();
            cs0 = 0; cn0 = 0; cs1 = 0; cn1 = 0; cp = 0;
            for (int i = 0; i < 16; i++) begin
                cs0 += int'(bus.PWM_sig[0]);
                cn0 += int'(bus.PWM_sig_n[0]);
                cs1 += int'(bus.PWM_sig[1]);
                cn1 += int'(bus.PWM_sig_n[1]);
                cp  += int'(bus.period_st);
                @(negedge clk);
            end
            e = sb_q.pop_front();
            chk($sformatf("v%0d_sig0", v),   32'(cs0), 32'(e.s0));
            chk($sformatf("v%0d_sig_n0", v), 32'(cn0), 32'(e.n0));
            chk($sformatf("v%0d_sig1", v),   32'(cs1), 32'(e.s1));
            chk($sformatf("v%0d_sig_n1", v), 32'(cn1), 32'(e.n1));
            chk($sformatf("v%0d_pst", v),    32'(cp),  32'd1);
        end

        // Shadow: write at cnt=5 lands next period; write at cnt=15 lands one period later.
        apply_duty(W'(8), W'(0), DW'(0));
        repeat (3) wait_pst();
        run_window(5, W'(2), hi);
        chk("shadow_mid_write_cur", 32'(hi), 32'd8);
        run_window(15, W'(6), hi);
        chk("shadow_mid_write_next", 32'(hi), 32'd2);
        run_window(-1, W'(0), hi);
        chk("shadow_wr15_next", 32'(hi), 32'd2);
        run_window(-1, W'(0), hi);
        chk("shadow_wr15_later", 32'(hi), 32'd6);
        bus.duty_wr = 1'b0;

        // en dropped while ch0 is HI with D=2.
        apply_duty(W'(8), W'(0), DW'(2));
        repeat (3) wait_pst();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.PWM_sig[0]) found = 1'b1;
        end
        chk("en_drop_hi_seen", 32'(found), 32'd1);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("en_drop_k%0d", k), 32'({bus.PWM_sig[0], bus.PWM_sig_n[0]}), 32'(drop_exp[k]));
            chk($sformatf("en_drop_pst_k%0d", k), 32'(bus.period_st), 32'd0);
        end
        bus.en = 1'b1;

        // Reset asserted in the first DHI cycle of ch0 (D=5).
        apply_duty(W'(8), W'(0), DW'(5));
        repeat (3) wait_pst();
        found  = 1'b0;
        prev_n = bus.PWM_sig_n[0];
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (prev_n && !bus.PWM_sig_n[0] && !bus.PWM_sig[0]) found = 1'b1;
            prev_n = bus.PWM_sig_n[0];
        end
        chk("dhi_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("dhi_rst_sig",   32'(bus.PWM_sig),   32'd0);
        chk("dhi_rst_sig_n", 32'(bus.PWM_sig_n), 32'd3);
        chk("dhi_rst_pst",   32'(bus.period_st), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
